healer_event_tracer: RTL and testbench
======================================

# healer_event_tracer

Synthesizable, multi-train successor to the simulation-only healer CSV logger. Each cycle it classifies the booking/fault/heal activity of every train channel. It time-stamps non-idle events and stores them in a circular trace buffer that a host drains over a valid/ready port. It also keeps a per-channel history of recent fault timestamps and sticky overflow and drop statistics, so fault-tolerance behaviour can be inspected on hardware and in simulation alike.

## Interface
- NUM_TRAINS, 4, number of train channels (1..16); CH_W = max(1, clog2(NUM_TRAINS))
- DEPTH, 16, trace buffer entries (power of two, ≥2)
- HIST_DEPTH, 3, fault timestamps kept per channel (≥1)
- TS_W, 32, timestamp width
- CNT_W, 10, booked_count / fare width
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- book_req  in  NUM_TRAINS  per-channel booking request
- success  in  NUM_TRAINS  per-channel booking success
- fault_flag  in  NUM_TRAINS  per-channel fault detected
- heal_trigger  in  NUM_TRAINS  per-channel heal action
- heal_mode  in  2*NUM_TRAINS  channel c at [2c+1:2c]; 2'b10 seat correction, 2'b01 compensation
- booked_count  in  CNT_W*NUM_TRAINS  channel c at [CNT_W*c +: CNT_W]
- fare  in  CNT_W*NUM_TRAINS  same packing
- ev_valid  out  1  head entry available
- ev_ready  in  1  host accepts head entry
- ev_ts  out  TS_W  head timestamp
- ev_chan  out  CH_W  head channel index
- ev_code  out  3  head event code
- ev_count  out  CNT_W  head booked_count
- ev_fare  out  CNT_W  head fare
- fill  out  clog2(DEPTH)+1  entries stored
- overflow  out  1  sticky: an event was lost because the buffer was full
- drop_count  out  16  saturating count of lost events
- clr_stats  in  1  clears overflow and drop_count
- hist_sel  in  CH_W  channel for fault-history readout
- hist_idx  in  clog2(HIST_DEPTH) or 1  0 = newest
- hist_ts  out  TS_W  combinational read of history[hist_sel][hist_idx]

## Operation
- Cycle counter cyc: 0 after reset, +1 every non-reset cycle, wraps at 2^TS_W.
- Per-channel classification, priority order:
  - book_req&success → 1 BOOK_OK
  - book_req&!success → 2 BOOK_FAIL
  - fault_flag&!heal_trigger → 3 FAULT
  - heal_trigger&mode==10 → 4 SEAT_CORR
  - heal_trigger&mode==01 → 5 COMP
  - else 0 IDLE
- Arbitration: among channels with a non-idle code, the lowest index wins and is captured as {cyc, chan, code, booked_count[c], fare[c]}. Every other non-idle channel in that cycle counts as one drop.
- Push when a winner exists and the buffer is not full, or when it is full and the same cycle pops. Otherwise the winner also counts as a drop and overflow sets.
- Pop when ev_valid & ev_ready.
- Circular buffer: write/read pointers wrap modulo DEPTH; fill tracks push minus pop.
- drop_count adds the number of drops per cycle (0..NUM_TRAINS) and saturates at 0xFFFF.
- clr_stats clears overflow and drop_count. If drops occur in the same cycle, the result is overflow = (new loss from full buffer) and drop_count = that cycle's drops.
- Fault history: on fault_flag[c]=1, regardless of arbitration, history[c] shifts (entry k ← k-1) and entry 0 ← cyc.
- Reset: pointers, fill, cyc, overflow, drop_count and all history entries → 0; ev_valid=0. Head data outputs are don't-care while ev_valid=0.

## Timing
- Event sampled in cycle n becomes visible at the head (ev_valid=1) at n+1 if the buffer was empty. ev_ts = cyc value during cycle n.
- Head outputs are stable while ev_valid & !ev_ready.
- fill and ev_valid update on the clock edge after push/pop. Push and pop in the same cycle leave fill unchanged.
- A reset asserted mid-drain discards all entries; ev_valid=0 on the following cycle.
- hist_ts reflects register state with no added latency. A fault in cycle n is readable from cycle n+1.

## Test plan
- Reset, then channel 2 book_req=1, success=1, count=37, fare=120 at cyc=5 → at cyc=6 ev_valid=1, ev_chan=2, ev_code=1, ev_ts=5, ev_count=37, ev_fare=120.
- Channels 0, 1 and 3 raise fault_flag together at cyc=9 → one entry (chan 0, code 3); drop_count=2; history[1][0]=9 and history[3][0]=9.
- ev_ready=0, 17 consecutive BOOK_FAIL events with DEPTH=16 → fill=16, overflow=1, drop_count=1. Drain → 16 entries in order with timestamps ascending by 1.
- Buffer full with ev_ready=1 and a new event in the same cycle → push accepted, fill stays 16, overflow stays 0.
- Channel 0 faults at cyc 3, 7, 11, 15 → hist_idx 0/1/2 read 15/11/7. heal_trigger=1 with mode=11 and no other inputs → no entry.
- drop_count preloaded to 0xFFFF by 65535 drops, then one more drop → stays 0xFFFF. clr_stats → 0. Reset mid-drain → ev_valid=0, fill=0.

Source files
------------

// File: rtl/healer_event_tracer.sv
// Multi-train booking/fault/heal event tracer: classifies per-channel activity,
// time-stamps it into a circular trace buffer and keeps per-channel fault history.
module healer_event_tracer #(
  parameter int unsigned NUM_TRAINS = 4,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned HIST_DEPTH = 3,
  parameter int unsigned TS_W       = 32,
  parameter int unsigned CNT_W      = 10,
  localparam int unsigned CH_W      = (NUM_TRAINS > 1) ? $clog2(NUM_TRAINS) : 1,
  localparam int unsigned HI_W      = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1,
  localparam int unsigned FILL_W    = $clog2(DEPTH) + 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_TRAINS-1:0]       book_req,
  input  logic [NUM_TRAINS-1:0]       success,
  input  logic [NUM_TRAINS-1:0]       fault_flag,
  input  logic [NUM_TRAINS-1:0]       heal_trigger,
  input  logic [2*NUM_TRAINS-1:0]     heal_mode,
  input  logic [CNT_W*NUM_TRAINS-1:0] booked_count,
  input  logic [CNT_W*NUM_TRAINS-1:0] fare,
  output logic                        ev_valid,
  input  logic                        ev_ready,
  output logic [TS_W-1:0]             ev_ts,
  output logic [CH_W-1:0]             ev_chan,
  output logic [2:0]                  ev_code,
  output logic [CNT_W-1:0]            ev_count,
  output logic [CNT_W-1:0]            ev_fare,
  output logic [FILL_W-1:0]           fill,
  output logic                        overflow,
  output logic [15:0]                 drop_count,
  input  logic                        clr_stats,
  input  logic [CH_W-1:0]             hist_sel,
  input  logic [HI_W-1:0]             hist_idx,
  output logic [TS_W-1:0]             hist_ts
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned DROP_W = 5;

  logic [TS_W-1:0]   cyc;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [TS_W-1:0]   mem_ts    [DEPTH];
  logic [CH_W-1:0]   mem_chan  [DEPTH];
  logic [2:0]        mem_code  [DEPTH];
  logic [CNT_W-1:0]  mem_count [DEPTH];
  logic [CNT_W-1:0]  mem_fare  [DEPTH];
  logic [TS_W-1:0]   hist      [NUM_TRAINS][HIST_DEPTH];

  logic [2:0]        code [NUM_TRAINS];
  logic              win_any;
  logic [CH_W-1:0]   win_ch;
  logic [2:0]        win_code;
  logic [CNT_W-1:0]  win_count, win_fare;
  logic [DROP_W-1:0] nonidle_cnt, drops;
  logic              full, push, pop, lost;
  logic [15:0]       drop_base, drop_next;
  logic [16:0]       drop_sum;

  // Per-channel classification, booking outranks fault outranks heal
  always_comb begin
    for (int c = 0; c < int'(NUM_TRAINS); c++) begin
      code[c] = 3'd0;
      if (book_req[c])
        code[c] = success[c] ? 3'd1 : 3'd2;
      else if (fault_flag[c] && !heal_trigger[c])
        code[c] = 3'd3;
      else if (heal_trigger[c] && heal_mode[2*c +: 2] == 2'b10)
        code[c] = 3'd4;
      else if (heal_trigger[c] && heal_mode[2*c +: 2] == 2'b01)
        code[c] = 3'd5;
    end
  end

  // Lowest-index non-idle channel wins; all active channels are counted
  always_comb begin
    win_any     = 1'b0;
    win_ch      = '0;
    win_code    = 3'd0;
    win_count   = '0;
    win_fare    = '0;
    nonidle_cnt = '0;
    for (int c = 0; c < int'(NUM_TRAINS); c++) begin
      if (code[c] != 3'd0) begin
        nonidle_cnt = nonidle_cnt + DROP_W'(1);
        if (!win_any) begin
          win_any   = 1'b1;
          win_ch    = CH_W'(c);
          win_code  = code[c];
          win_count = booked_count[CNT_W*c +: CNT_W];
          win_fare  = fare[CNT_W*c +: CNT_W];
        end
      end
    end
  end

  assign ev_valid = (fill != '0);
  assign full     = (fill == FILL_W'(DEPTH));
  assign pop      = ev_valid & ev_ready;
  assign push     = win_any & (~full | pop);
  assign lost     = win_any & ~push;
  assign drops    = nonidle_cnt - DROP_W'(win_any) + DROP_W'(lost);

  // A clear in the same cycle keeps only this cycle's drops
  always_comb begin
    drop_base = clr_stats ? 16'd0 : drop_count;
    drop_sum  = {1'b0, drop_base} + 17'(drops);
    drop_next = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc        <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill       <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
      for (int c = 0; c < int'(NUM_TRAINS); c++)
        for (int k = 0; k < int'(HIST_DEPTH); k++)
          hist[c][k] <= '0;
    end else begin
      cyc        <= cyc + TS_W'(1);
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      fill       <= fill + FILL_W'(push) - FILL_W'(pop);
      overflow   <= clr_stats ? lost : (overflow | lost);
      drop_count <= drop_next;
      for (int c = 0; c < int'(NUM_TRAINS); c++) begin
        if (fault_flag[c]) begin
          for (int k = int'(HIST_DEPTH) - 1; k > 0; k--)
            hist[c][k] <= hist[c][k-1];
          hist[c][0] <= cyc;
        end
      end
    end
  end

  // Trace storage carries no reset; only the pointers qualify it
  always_ff @(posedge clk) begin
    if (push) begin
      mem_ts[wr_ptr]    <= cyc;
      mem_chan[wr_ptr]  <= win_ch;
      mem_code[wr_ptr]  <= win_code;
      mem_count[wr_ptr] <= win_count;
      mem_fare[wr_ptr]  <= win_fare;
    end
  end

  assign ev_ts    = mem_ts[rd_ptr];
  assign ev_chan  = mem_chan[rd_ptr];
  assign ev_code  = mem_code[rd_ptr];
  assign ev_count = mem_count[rd_ptr];
  assign ev_fare  = mem_fare[rd_ptr];

  always_comb begin
    hist_ts = '0;
    if (32'(hist_sel) < NUM_TRAINS && 32'(hist_idx) < HIST_DEPTH)
      hist_ts = hist[hist_sel][hist_idx];
  end

endmodule

// File: tb/tb_healer_event_tracer.sv
// Directed, table-driven self-checking bench for healer_event_tracer.
module tb_healer_event_tracer;

  localparam int unsigned NT    = 4;
  localparam int unsigned CNT_W = 10;
  localparam int unsigned TS_W  = 32;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NT-1:0]          book_req, success, fault_flag, heal_trigger;
  logic [2*NT-1:0]        heal_mode;
  logic [CNT_W*NT-1:0]    booked_count, fare;
  logic                   ev_valid, ev_ready;
  logic [TS_W-1:0]        ev_ts;
  logic [1:0]             ev_chan;
  logic [2:0]             ev_code;
  logic [CNT_W-1:0]       ev_count, ev_fare;
  logic [4:0]             fill;
  logic                   overflow;
  logic [15:0]            drop_count;
  logic                   clr_stats;
  logic [1:0]             hist_sel;
  logic [1:0]             hist_idx;
  logic [TS_W-1:0]        hist_ts;

  int checks = 0;
  int failures = 0;
  int unsigned tcyc = 0;

  always #5 clk = ~clk;

  healer_event_tracer dut (
    .clk(clk), .rst(rst), .book_req(book_req), .success(success),
    .fault_flag(fault_flag), .heal_trigger(heal_trigger), .heal_mode(heal_mode),
    .booked_count(booked_count), .fare(fare), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_ts(ev_ts), .ev_chan(ev_chan), .ev_code(ev_code), .ev_count(ev_count),
    .ev_fare(ev_fare), .fill(fill), .overflow(overflow), .drop_count(drop_count),
    .clr_stats(clr_stats), .hist_sel(hist_sel), .hist_idx(hist_idx), .hist_ts(hist_ts)
  );

  typedef struct {
    int         ch;
    logic       br, su, ff, ht;
    logic [1:0] mode;
    logic       exp_valid;
    logic [2:0] exp_code;
  } vec_t;

  vec_t vt[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, tcyc);
    end
  endtask

  task automatic idle_in();
    book_req = '0; success = '0; fault_flag = '0; heal_trigger = '0;
    heal_mode = '0; booked_count = '0; fare = '0; clr_stats = 1'b0;
  endtask

  task automatic set_ch(input int c, input logic br, input logic su, input logic ff,
                        input logic ht, input logic [1:0] m,
                        input logic [CNT_W-1:0] cnt, input logic [CNT_W-1:0] fr);
    book_req[c] = br; success[c] = su; fault_flag[c] = ff; heal_trigger[c] = ht;
    heal_mode[2*c +: 2] = m;
    booked_count[CNT_W*c +: CNT_W] = cnt;
    fare[CNT_W*c +: CNT_W] = fr;
  endtask

  // One clock: inputs set at negedge are sampled at posedge, outputs read at next negedge
  task automatic step();
    @(posedge clk);
    tcyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; ev_ready = 1'b0; idle_in();
    step(); step();
    rst = 1'b0;
    tcyc = 0;
  endtask

  task automatic run_until(input int unsigned t);
    while (tcyc < t) step();
  endtask

  task automatic read_hist(input int c, input int k, input logic [31:0] exp, input string name);
    hist_sel = 2'(c); hist_idx = 2'(k);
    #1;
    chk(name, hist_ts, exp);
  endtask

  initial begin
    int unsigned t0;
    int unsigned ts_at;

    vt[0]  = '{1, 1, 1, 0, 0, 2'b00, 1'b1, 3'd1};
    vt[1]  = '{3, 1, 0, 0, 0, 2'b00, 1'b1, 3'd2};
    vt[2]  = '{0, 1, 1, 1, 0, 2'b00, 1'b1, 3'd1};
    vt[3]  = '{2, 0, 0, 1, 0, 2'b00, 1'b1, 3'd3};
    vt[4]  = '{2, 0, 0, 1, 1, 2'b10, 1'b1, 3'd4};
    vt[5]  = '{1, 0, 0, 0, 1, 2'b10, 1'b1, 3'd4};
    vt[6]  = '{0, 0, 0, 0, 1, 2'b01, 1'b1, 3'd5};
    vt[7]  = '{3, 0, 0, 0, 1, 2'b11, 1'b0, 3'd0};
    vt[8]  = '{0, 0, 0, 0, 1, 2'b00, 1'b0, 3'd0};
    vt[9]  = '{2, 0, 0, 1, 1, 2'b11, 1'b0, 3'd0};
    vt[10] = '{1, 0, 1, 0, 0, 2'b00, 1'b0, 3'd0};

    hist_sel = '0; hist_idx = '0;
    do_reset();
    chk("rst_valid", ev_valid, 0);
    chk("rst_fill", fill, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_drops", drop_count, 0);
    read_hist(3, 2, 0, "rst_hist");

    // Single booking at cyc 5
    run_until(5);
    set_ch(2, 1, 1, 0, 0, 2'b00, 10'd37, 10'd120);
    step(); idle_in();
    chk("b1_valid", ev_valid, 1);
    chk("b1_chan", ev_chan, 2);
    chk("b1_code", ev_code, 1);
    chk("b1_ts", ev_ts, 5);
    chk("b1_count", ev_count, 37);
    chk("b1_fare", ev_fare, 120);
    ev_ready = 1'b1; step(); ev_ready = 1'b0;
    chk("b1_popped", ev_valid, 0);

    // Three simultaneous faults at cyc 9
    run_until(9);
    set_ch(0, 0, 0, 1, 0, 2'b00, 10'd0, 10'd0);
    set_ch(1, 0, 0, 1, 0, 2'b00, 10'd0, 10'd0);
    set_ch(3, 0, 0, 1, 0, 2'b00, 10'd0, 10'd0);
    step(); idle_in();
    chk("f3_fill", fill, 1);
    chk("f3_chan", ev_chan, 0);
    chk("f3_code", ev_code, 3);
    chk("f3_ts", ev_ts, 9);
    chk("f3_drops", drop_count, 2);
    read_hist(1, 0, 9, "f3_hist1");
    read_hist(3, 0, 9, "f3_hist3");
    read_hist(1, 1, 0, "f3_hist1_old");
    read_hist(2, 0, 0, "f3_hist2");
    ev_ready = 1'b1; step(); ev_ready = 1'b0;

    // Classification table
    for (int i = 0; i < 11; i++) begin
      idle_in();
      set_ch(vt[i].ch, vt[i].br, vt[i].su, vt[i].ff, vt[i].ht, vt[i].mode,
             10'(i + 1), 10'(i + 200));
      ts_at = tcyc;
      step(); idle_in();
      chk("tbl_valid", ev_valid, vt[i].exp_valid);
      if (vt[i].exp_valid) begin
        chk("tbl_code", ev_code, vt[i].exp_code);
        chk("tbl_chan", ev_chan, vt[i].ch);
        chk("tbl_ts", ev_ts, ts_at);
        chk("tbl_count", ev_count, i + 1);
      end
      ev_ready = 1'b1; step(); ev_ready = 1'b0;
      chk("tbl_drained", fill, 0);
    end
    chk("tbl_drops", drop_count, 2);

    // Overflow: 17 BOOK_FAIL events into a 16-entry buffer
    clr_stats = 1'b1; step(); idle_in();
    chk("ov_clr_drops", drop_count, 0);
    t0 = tcyc;
    for (int i = 0; i < 17; i++) begin
      set_ch(0, 1, 0, 0, 0, 2'b00, 10'(i), 10'(i + 100));
      step(); idle_in();
    end
    chk("ov_fill", fill, 16);
    chk("ov_overflow", overflow, 1);
    chk("ov_drops", drop_count, 1);
    for (int i = 0; i < 16; i++) begin
      chk("ov_drain_valid", ev_valid, 1);
      chk("ov_drain_ts", ev_ts, t0 + i);
      chk("ov_drain_count", ev_count, i);
      chk("ov_drain_code", ev_code, 2);
      ev_ready = 1'b1; step(); ev_ready = 1'b0;
    end
    chk("ov_empty_valid", ev_valid, 0);
    chk("ov_empty_fill", fill, 0);
    chk("ov_sticky", overflow, 1);

    // Full buffer with simultaneous pop and push
    clr_stats = 1'b1; step(); idle_in();
    chk("fp_clr_overflow", overflow, 0);
    t0 = tcyc;
    for (int i = 0; i < 16; i++) begin
      set_ch(3, 1, 1, 0, 0, 2'b00, 10'(i), 10'(i));
      step(); idle_in();
    end
    step();
    chk("fp_head_stable", ev_ts, t0);
    set_ch(1, 1, 1, 0, 0, 2'b00, 10'd99, 10'd99);
    ev_ready = 1'b1;
    step(); idle_in(); ev_ready = 1'b0;
    chk("fp_fill", fill, 16);
    chk("fp_overflow", overflow, 0);
    chk("fp_drops", drop_count, 0);
    chk("fp_head", ev_ts, t0 + 1);
    ev_ready = 1'b1; step(); step();
    chk("fp_fill14", fill, 14);
    rst = 1'b1; step(); rst = 1'b0; ev_ready = 1'b0; tcyc = 0;
    chk("mid_rst_valid", ev_valid, 0);
    chk("mid_rst_fill", fill, 0);

    // Fault history on channel 0 at cyc 3,7,11,15
    while (tcyc < 16) begin
      logic f;
      int unsigned ft;
      idle_in();
      f = (tcyc % 4 == 3);
      ft = tcyc;
      if (f) set_ch(0, 0, 0, 1, 0, 2'b00, 10'd0, 10'd0);
      step(); idle_in();
      if (f) read_hist(0, 0, ft, "h_newest");
    end
    read_hist(0, 0, 15, "h_idx0");
    read_hist(0, 1, 11, "h_idx1");
    read_hist(0, 2, 7, "h_idx2");
    chk("h_fill", fill, 4);
    set_ch(0, 0, 0, 0, 1, 2'b11, 10'd0, 10'd0);
    step(); idle_in();
    chk("heal11_fill", fill, 4);
    chk("heal11_drops", drop_count, 0);

    // drop_count saturation: 3 drops per cycle with the buffer draining every cycle
    do_reset();
    ev_ready = 1'b1;
    for (int n = 0; n < 21844; n++) begin
      for (int c = 0; c < 4; c++) set_ch(c, 1, 1, 0, 0, 2'b00, 10'd1, 10'd1);
      step();
    end
    chk("sat_pre", drop_count, 65532);
    step(); idle_in();
    chk("sat_ffff", drop_count, 16'hFFFF);
    set_ch(0, 1, 1, 0, 0, 2'b00, 10'd1, 10'd1);
    set_ch(1, 1, 1, 0, 0, 2'b00, 10'd1, 10'd1);
    step(); idle_in();
    chk("sat_hold", drop_count, 16'hFFFF);
    chk("sat_overflow", overflow, 0);
    clr_stats = 1'b1; step(); idle_in();
    chk("clr_drops", drop_count, 0);
    clr_stats = 1'b1;
    for (int c = 0; c < 3; c++) set_ch(c, 1, 0, 0, 0, 2'b00, 10'd1, 10'd1);
    step(); idle_in();
    chk("clr_same_cycle", drop_count, 2);
    chk("clr_same_overflow", overflow, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
